// File: rtl/seq_alu_pkg.sv
// Shared opcode, FSM state and flag definitions for the sequential ALU.
package seq_alu_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] OPC_ADD = 4'b0000;
   localparam logic [OP_W-1:0] OPC_SUB = 4'b0001;
   localparam logic [OP_W-1:0] OPC_MUL = 4'b0010;
   localparam logic [OP_W-1:0] OPC_DIV = 4'b0011;
   localparam logic [OP_W-1:0] OPC_MOD = 4'b0100;
   localparam logic [OP_W-1:0] OPC_AND = 4'b0101;
   localparam logic [OP_W-1:0] OPC_OR  = 4'b0110;
   localparam logic [OP_W-1:0] OPC_XOR = 4'b0111;
   localparam logic [OP_W-1:0] OPC_SHL = 4'b1000;
   localparam logic [OP_W-1:0] OPC_SHR = 4'b1001;
   localparam logic [OP_W-1:0] OPC_ROL = 4'b1010;
   localparam logic [OP_W-1:0] OPC_ROR = 4'b1011;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = OPC_ADD,
      OP_SUB = OPC_SUB,
      OP_MUL = OPC_MUL,
      OP_DIV = OPC_DIV,
      OP_MOD = OPC_MOD,
      OP_AND = OPC_AND,
      OP_OR  = OPC_OR,
      OP_XOR = OPC_XOR,
      OP_SHL = OPC_SHL,
      OP_SHR = OPC_SHR,
      OP_ROL = OPC_ROL,
      OP_ROR = OPC_ROR
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } alu_state_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } alu_flags_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/result handshake bundle between a requester and seq_alu.
interface seq_alu_if #(
   parameter int unsigned WIDTH = 8
);
   import seq_alu_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      a;
   logic [WIDTH-1:0]      b;
   logic [OP_W-1:0]       op;
   logic                  out_valid;
   logic                  out_ready;
   logic [2*WIDTH-1:0]    result;
   logic                  n;
   logic                  z;
   logic                  c;
   logic                  v;
   logic                  err;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, n, z, c, v, err
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, n, z, c, v, err
   );

endinterface

// File: rtl/seq_alu_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; the start cycle
// performs the first step straight from the inputs so o_done rises WIDTH edges later.
module seq_alu_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [WIDTH-1:0] r_rem, r_quo, r_dsr;
   logic [CW-1:0]    r_cnt;
   logic             r_busy, r_done;

   logic [WIDTH-1:0] w_rem_in, w_quo_in, w_dsr_in, w_rem_nxt, w_quo_nxt;
   logic [WIDTH:0]   w_shift, w_trial;
   logic             w_ge;

   assign w_rem_in  = i_start ? '0         : r_rem;
   assign w_quo_in  = i_start ? i_dividend : r_quo;
   assign w_dsr_in  = i_start ? i_divisor  : r_dsr;

   // Shifted partial remainder can exceed WIDTH bits, so compare before subtracting
   assign w_shift   = {w_rem_in, w_quo_in[WIDTH-1]};
   assign w_ge      = (w_shift >= {1'b0, w_dsr_in});
   assign w_trial   = w_shift - {1'b0, w_dsr_in};
   assign w_rem_nxt = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_quo_nxt = {w_quo_in[WIDTH-2:0], w_ge};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem  <= '0;
         r_quo  <= '0;
         r_dsr  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_rem  <= w_rem_nxt;
            r_quo  <= w_quo_nxt;
            r_dsr  <= i_divisor;
            r_cnt  <= CW'(1);
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH-1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_done      = r_done;
   assign o_quotient  = r_quo;
   assign o_remainder = r_rem;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic/shift, shift-add multiply,
// restoring divide. Define SEQ_ALU_ROT_EN to enable ROL/ROR opcodes.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   seq_alu_if.slave    bus
);

   localparam int unsigned CW  = $clog2(WIDTH);
   localparam int unsigned RW  = 2 * WIDTH;
   localparam int unsigned SHW = WIDTH + 1;

   alu_state_t       r_state, w_state_nxt;
   alu_op_t          r_op, w_op_nxt, w_op;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [RW-1:0]    r_mcand, w_mcand_nxt, r_acc, w_acc_nxt, w_acc_add;
   logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
   logic [RW-1:0]    r_result, w_result_nxt;
   alu_flags_t       r_flags, w_flags_nxt;
   logic             r_err, w_err_nxt;
   logic             r_out_valid, w_out_valid_nxt;
   logic             r_in_ready, w_in_ready_nxt;

   logic [RW-1:0]    w_sc_res, w_a_ext, w_div_res;
   alu_flags_t       w_sc_flags;
   logic             w_sc_err, w_sc_bad, w_shift_oor;
   logic [WIDTH:0]   w_sum, w_dif;
   logic             w_div_start, w_div_done;
   logic [WIDTH-1:0] w_quo, w_rem;

   assign w_op        = alu_op_t'(bus.op);
   assign w_a_ext     = RW'(bus.a);
   assign w_sum       = {1'b0, bus.a} + {1'b0, bus.b};
   assign w_dif       = {1'b0, bus.a} - {1'b0, bus.b};
   assign w_shift_oor = (SHW'(bus.b) >= SHW'(RW));
   assign w_acc_add   = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_div_res   = (r_op == OP_MOD) ? RW'(w_rem) : RW'(w_quo);

`ifdef SEQ_ALU_ROT_EN
   localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
   logic [WIDTH-1:0] w_rot_amt, w_rol, w_ror;
   assign w_rot_amt = bus.b % W_VAL;
   assign w_rol     = (bus.a << w_rot_amt) | (bus.a >> (W_VAL - w_rot_amt));
   assign w_ror     = (bus.a >> w_rot_amt) | (bus.a << (W_VAL - w_rot_amt));
`endif

   seq_alu_divider #(.WIDTH(WIDTH)) u_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (w_div_start),
      .i_dividend  (bus.a),
      .i_divisor   (bus.b),
      .o_done      (w_div_done),
      .o_quotient  (w_quo),
      .o_remainder (w_rem)
   );

   // Single-cycle datapath, evaluated on the live request
   always_comb begin
      w_sc_res   = '0;
      w_sc_flags = '0;
      w_sc_err   = 1'b0;
      w_sc_bad   = 1'b0;
      case (w_op)
         OP_ADD: begin
            w_sc_res     = RW'(w_sum[WIDTH-1:0]);
            w_sc_flags.c = w_sum[WIDTH];
            w_sc_flags.v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            w_sc_res     = RW'(w_dif[WIDTH-1:0]);
            w_sc_flags.c = w_dif[WIDTH];
            w_sc_flags.v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_dif[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_MUL: w_sc_res = '0;
         OP_DIV: begin
            w_sc_res = '1;
            w_sc_err = 1'b1;
         end
         OP_MOD: begin
            w_sc_res = w_a_ext;
            w_sc_err = 1'b1;
         end
         OP_AND: w_sc_res = RW'(bus.a & bus.b);
         OP_OR:  w_sc_res = RW'(bus.a | bus.b);
         OP_XOR: w_sc_res = RW'(bus.a ^ bus.b);
         OP_SHL: w_sc_res = w_shift_oor ? '0 : (w_a_ext << bus.b);
         OP_SHR: w_sc_res = w_shift_oor ? '0 : RW'(bus.a >> bus.b);
`ifdef SEQ_ALU_ROT_EN
         OP_ROL: begin
            w_sc_res     = RW'(w_rol);
            w_sc_flags.c = (w_rot_amt != '0) && w_rol[0];
         end
         OP_ROR: begin
            w_sc_res     = RW'(w_ror);
            w_sc_flags.c = (w_rot_amt != '0) && w_ror[WIDTH-1];
         end
`endif
         default: begin
            w_sc_err = 1'b1;
            w_sc_bad = 1'b1;
         end
      endcase
      if (!w_sc_bad) begin
         w_sc_flags.n = (w_op == OP_SHL) ? w_sc_res[RW-1] : w_sc_res[WIDTH-1];
         w_sc_flags.z = ~|w_sc_res;
      end
   end

   // Next-state and next-register logic
   always_comb begin
      w_state_nxt     = r_state;
      w_op_nxt        = r_op;
      w_cnt_nxt       = r_cnt;
      w_mcand_nxt     = r_mcand;
      w_mplier_nxt    = r_mplier;
      w_acc_nxt       = r_acc;
      w_result_nxt    = r_result;
      w_flags_nxt     = r_flags;
      w_err_nxt       = r_err;
      w_out_valid_nxt = r_out_valid;
      w_in_ready_nxt  = r_in_ready;
      w_div_start     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready_nxt = 1'b1;
            if (r_in_ready && bus.in_valid) begin
               w_op_nxt       = w_op;
               w_cnt_nxt      = '0;
               w_in_ready_nxt = 1'b0;
               if (w_op == OP_MUL) begin
                  w_state_nxt  = ST_MUL;
                  w_mcand_nxt  = w_a_ext;
                  w_mplier_nxt = bus.b;
                  w_acc_nxt    = '0;
               end else if ((w_op == OP_DIV || w_op == OP_MOD) && (bus.b != '0)) begin
                  w_state_nxt  = ST_DIV;
                  w_div_start  = 1'b1;
               end else begin
                  w_state_nxt     = ST_DONE;
                  w_out_valid_nxt = 1'b1;
                  w_result_nxt    = w_sc_res;
                  w_flags_nxt     = w_sc_flags;
                  w_err_nxt       = w_sc_err;
               end
            end
         end
         ST_MUL: begin
            w_acc_nxt    = w_acc_add;
            w_mcand_nxt  = r_mcand << 1;
            w_mplier_nxt = r_mplier >> 1;
            w_cnt_nxt    = r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH-1)) begin
               w_state_nxt     = ST_DONE;
               w_out_valid_nxt = 1'b1;
               w_result_nxt    = w_acc_add;
               w_flags_nxt     = '0;
               w_flags_nxt.n   = w_acc_add[RW-1];
               w_flags_nxt.z   = ~|w_acc_add;
               w_err_nxt       = 1'b0;
            end
         end
         ST_DIV: begin
            if (w_div_done) begin
               w_state_nxt     = ST_DONE;
               w_out_valid_nxt = 1'b1;
               w_result_nxt    = w_div_res;
               w_flags_nxt     = '0;
               w_flags_nxt.n   = w_div_res[WIDTH-1];
               w_flags_nxt.z   = ~|w_div_res;
               w_err_nxt       = 1'b0;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               w_state_nxt     = ST_IDLE;
               w_out_valid_nxt = 1'b0;
               w_in_ready_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_ADD;
         r_cnt       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_result    <= '0;
         r_flags     <= '0;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_op        <= w_op_nxt;
         r_cnt       <= w_cnt_nxt;
         r_mcand     <= w_mcand_nxt;
         r_mplier    <= w_mplier_nxt;
         r_acc       <= w_acc_nxt;
         r_result    <= w_result_nxt;
         r_flags     <= w_flags_nxt;
         r_err       <= w_err_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_in_ready  <= w_in_ready_nxt;
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.n         = r_flags.n;
   assign bus.z         = r_flags.z;
   assign bus.c         = r_flags.c;
   assign bus.v         = r_flags.v;
   assign bus.err       = r_err;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=4.
module tb_seq_alu;

   localparam int unsigned W = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_err    = 0;

   seq_alu_if #(.WIDTH(W)) bus ();

   seq_alu #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [7:0] exp_res,
                         input logic [3:0] exp_nzcv, input logic exp_err,
                         input int exp_lat, input int hold);
      int   lat;
      logic busy_ready;
      for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) tick();
      check({tag, " in_ready_idle"}, 64'(bus.in_ready), 64'd1);
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.a        = ~a;
      bus.b        = ~b;
      bus.op       = 4'hF;
      lat        = 1;
      busy_ready = 1'b0;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         busy_ready = busy_ready | bus.in_ready;
         tick();
         lat++;
      end
      busy_ready = busy_ready | bus.in_ready;
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " in_ready_busy"}, 64'(busy_ready), 64'd0);
      check({tag, " result"}, 64'(bus.result), 64'(exp_res));
      check({tag, " nzcv"}, 64'({bus.n, bus.z, bus.c, bus.v}), 64'(exp_nzcv));
      check({tag, " err"}, 64'(bus.err), 64'(exp_err));
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, " hold_valid"}, 64'(bus.out_valid), 64'd1);
         check({tag, " hold_result"}, 64'(bus.result), 64'(exp_res));
         check({tag, " hold_nzcv"}, 64'({bus.n, bus.z, bus.c, bus.v}), 64'(exp_nzcv));
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, " valid_drop"}, 64'(bus.out_valid), 64'd0);
      check({tag, " ready_back"}, 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = '0;
      #2;
      check("rst out_valid", 64'(bus.out_valid), 64'd0);
      check("rst result", 64'(bus.result), 64'd0);
      check("rst flags_err", 64'({bus.n, bus.z, bus.c, bus.v, bus.err}), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst in_ready", 64'(bus.in_ready), 64'd1);

      run_op("add_c_v",   4'b0000, 4'b1001, 4'b1010, 8'h03, 4'b0011, 1'b0, 1, 0);
      run_op("add_wrap",  4'b0000, 4'b1111, 4'b0001, 8'h00, 4'b0110, 1'b0, 1, 0);
      run_op("mul_5x5",   4'b0010, 4'b0101, 4'b0101, 8'h19, 4'b0000, 1'b0, 5, 0);
      run_op("mul_15x15", 4'b0010, 4'b1111, 4'b1111, 8'hE1, 4'b1000, 1'b0, 5, 0);
      run_op("div_13_2",  4'b0011, 4'b1101, 4'b0010, 8'h06, 4'b0000, 1'b0, 5, 0);
      run_op("div_15_1",  4'b0011, 4'b1111, 4'b0001, 8'h0F, 4'b1000, 1'b0, 5, 0);
      run_op("mod_9_6",   4'b0100, 4'b1001, 4'b0110, 8'h03, 4'b0000, 1'b0, 5, 0);
      run_op("sub_neg",   4'b0001, 4'b0011, 4'b0101, 8'h0E, 4'b1010, 1'b0, 1, 0);
      run_op("sub_ovf",   4'b0001, 4'b0111, 4'b1000, 8'h0F, 4'b1011, 1'b0, 1, 0);
      run_op("sub_hold",  4'b0001, 4'b1110, 4'b1110, 8'h00, 4'b0100, 1'b0, 1, 3);
      run_op("shl",       4'b1000, 4'b1011, 4'b0011, 8'h58, 4'b0000, 1'b0, 1, 0);
      run_op("shl_7",     4'b1000, 4'b1111, 4'b0111, 8'h80, 4'b1000, 1'b0, 1, 0);
      run_op("shl_oor",   4'b1000, 4'b1111, 4'b1000, 8'h00, 4'b0100, 1'b0, 1, 0);
      run_op("shr",       4'b1001, 4'b1100, 4'b0010, 8'h03, 4'b0000, 1'b0, 1, 0);
      run_op("shr_oor",   4'b1001, 4'b1111, 4'b1001, 8'h00, 4'b0100, 1'b0, 1, 0);
      run_op("and",       4'b0101, 4'b1100, 4'b1010, 8'h08, 4'b1000, 1'b0, 1, 0);
      run_op("or",        4'b0110, 4'b0101, 4'b0010, 8'h07, 4'b0000, 1'b0, 1, 0);
      run_op("xor",       4'b0111, 4'b1111, 4'b1111, 8'h00, 4'b0100, 1'b0, 1, 0);
      run_op("mod_b0",    4'b0100, 4'b1011, 4'b0000, 8'h0B, 4'b1000, 1'b1, 1, 0);
`ifdef SEQ_ALU_ROT_EN
      run_op("rol",       4'b1010, 4'b1001, 4'b0001, 8'h03, 4'b0010, 1'b0, 1, 0);
      run_op("ror_mod",   4'b1011, 4'b1001, 4'b0101, 8'h0C, 4'b1010, 1'b0, 1, 0);
`else
      run_op("rol_unsup", 4'b1010, 4'b1001, 4'b0001, 8'h00, 4'b0000, 1'b1, 1, 0);
      run_op("ror_unsup", 4'b1011, 4'b1001, 4'b0001, 8'h00, 4'b0000, 1'b1, 1, 0);
`endif
      run_op("op_unsup",  4'b1100, 4'b0110, 4'b0011, 8'h00, 4'b0000, 1'b1, 1, 0);
      run_op("div_b0",    4'b0011, 4'b0111, 4'b0000, 8'hFF, 4'b1000, 1'b1, 1, 0);

      // Abort a multiply mid-flight; outputs still hold the divide-by-zero result
      bus.op       = 4'b0010;
      bus.a        = 4'b0111;
      bus.b        = 4'b0011;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      check("abort busy in_ready", 64'(bus.in_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      check("abort out_valid", 64'(bus.out_valid), 64'd0);
      check("abort result", 64'(bus.result), 64'd0);
      check("abort flags_err", 64'({bus.n, bus.z, bus.c, bus.v, bus.err}), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("abort in_ready", 64'(bus.in_ready), 64'd1);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort no_output", 64'(bus.out_valid), 64'd0);
      end
      run_op("add_after", 4'b0000, 4'b0010, 4'b0011, 8'h05, 4'b0000, 1'b0, 1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal values 4 to 32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 op  input  4  opcode:
- 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 MOD
- 0101 AND, 0110 OR, 0111 XOR, 1000 SHL, 1001 SHR
- 1010 ROL, 1011 ROR
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  2*WIDTH  registered result.
REQ-012 n, z, c, v  output  1 each  registered flags.
REQ-013 err  output  1  divide by zero or unsupported opcode.

Function
REQ-014 The block SHALL be an FSM with states IDLE, MUL, DIV and DONE, and SHALL assert in_ready only in IDLE.
REQ-015 In IDLE, the block SHALL latch a, b and op when in_valid and in_ready are both high.
- MUL goes to state MUL.
- DIV and MOD with b!=0 go to state DIV.
- All other opcodes compute the result in that cycle and go to DONE.
REQ-016 MUL SHALL use shift-add, one bit per cycle, for WIDTH cycles; it then goes to DONE, giving out_valid WIDTH+1 cycles after acceptance.
REQ-017 DIV and MOD SHALL use restoring division, one bit per cycle, for WIDTH cycles; out_valid follows WIDTH+1 cycles after acceptance.
REQ-018 Single-cycle ops SHALL assert out_valid 1 cycle after acceptance.
REQ-019 In DONE, out_valid=1 and result, flags and err SHALL hold stable until out_ready=1; the block then returns to IDLE.
- No new request is accepted in that same cycle.
REQ-020 Result widths, unsigned:
- ADD and SUB: low WIDTH bits zero-extended.
- MUL: full 2*WIDTH product.
- DIV: quotient in the low bits.
- MOD: remainder in the low bits.
- Logic ops: zero-extended.
REQ-021 SHL SHALL shift zero-extended a left by b, truncated to 2*WIDTH. SHR SHALL shift a right by b. Any b >= 2*WIDTH SHALL give result 0.
REQ-022 n SHALL be the MSB of the significant field: bit 2*WIDTH-1 for MUL and SHL, bit WIDTH-1 otherwise.
REQ-023 z SHALL be 1 when result==0.
REQ-024 c SHALL be the carry-out for ADD and the borrow (a<b) for SUB; it SHALL be 0 for all other ops.
REQ-025 v SHALL be the two's-complement overflow for ADD and SUB; it SHALL be 0 otherwise.
REQ-026 DIV or MOD with b==0 SHALL complete in 1 cycle with result all-ones for DIV, result a for MOD, and err=1.
REQ-027 An unsupported opcode SHALL give result 0, all flags 0 and err=1 after 1 cycle.

Reset
REQ-028 rst_n low SHALL immediately set the state to IDLE and clear result, n, z, c, v, err, out_valid and the iteration counter. in_ready SHALL be 1 from the first edge after release.
REQ-029 Reset during MUL or DIV SHALL abort the operation with no output produced.

Configuration
REQ-030 With SEQ_ALU_ROT_EN defined, ROL and ROR SHALL rotate a within WIDTH bits by b mod WIDTH in a single cycle, with c equal to the last bit rotated.
REQ-031 Without SEQ_ALU_ROT_EN, opcodes 1010 and 1011 SHALL be treated as unsupported (REQ-027).

Structure
REQ-032 Package seq_alu_pkg SHALL hold:
- the alu_op_t opcode enum;
- the alu_state_t FSM enum;
- opcode localparams.
REQ-033 The restoring divider SHALL be sub-module seq_alu_divider, with start/done signals, parametrised by WIDTH; seq_alu SHALL instantiate it once.

Verification
REQ-034 WIDTH=4, ADD a=1001 b=1010 -> result 00000011, c=1, v=1, n=0, z=0, 1-cycle latency.
REQ-035 WIDTH=4, MUL a=0101 b=0101 -> result 00011001 with out_valid 5 cycles after acceptance; in_ready=0 throughout.
REQ-036 WIDTH=4, DIV a=1101 b=0010 -> result 00000110; MOD a=1001 b=0110 -> result 00000011, both 5-cycle latency; DIV b=0 -> result 11111111, err=1.
REQ-037 WIDTH=4, SUB a=1110 b=1110 with out_ready held 0 for 3 cycles -> result 0 and z=1 held stable, then handshake completes.
REQ-038 rst_n pulsed low mid-MUL -> out_valid=0 and all outputs 0 at once, in_ready=1 after release; opcode 1010 without SEQ_ALU_ROT_EN -> err=1.
